// File: rtl/switch_rr_arbiter_pkg.sv
// Shared router definitions: port indices, request/grant bit order, pointer reset.
package switch_rr_arbiter_pkg;

  localparam int unsigned NUM_PORTS = 4;
  localparam int unsigned PTR_W     = 2;

  // Request/grant vector: bit3 = L, bit2 = W, bit1 = E, bit0 = S (shared with the switch allocator)
  typedef logic [NUM_PORTS-1:0] port_vec_t;
  typedef logic [PTR_W-1:0]     ptr_t;

  localparam ptr_t IDX_L   = 2'd3;
  localparam ptr_t IDX_W   = 2'd2;
  localparam ptr_t IDX_E   = 2'd1;
  localparam ptr_t IDX_S   = 2'd0;

  // After reset the L input has highest priority on every output
  localparam ptr_t PTR_RST = IDX_L;

endpackage

// File: rtl/switch_rr_arbiter_if.sv
// Allocator <-> arbiter bundle: per-output requests/full in, one-hot grants and counters out.
interface switch_rr_arbiter_if #(
  parameter int unsigned CNTW = 16
);
  import switch_rr_arbiter_pkg::*;

  logic            en;
  logic            cnt_clr;
  port_vec_t       req_L;
  port_vec_t       req_W;
  port_vec_t       req_E;
  port_vec_t       req_S;
  logic            W_full;
  logic            E_full;
  logic            S_full;
  port_vec_t       L_arb_res;
  port_vec_t       W_arb_res;
  port_vec_t       E_arb_res;
  port_vec_t       S_arb_res;
  logic [CNTW-1:0] L_xfer_cnt;
  logic [CNTW-1:0] W_xfer_cnt;
  logic [CNTW-1:0] E_xfer_cnt;
  logic [CNTW-1:0] S_xfer_cnt;

  // Switch allocator side
  modport master (
    output en, cnt_clr, req_L, req_W, req_E, req_S, W_full, E_full, S_full,
    input  L_arb_res, W_arb_res, E_arb_res, S_arb_res,
    input  L_xfer_cnt, W_xfer_cnt, E_xfer_cnt, S_xfer_cnt
  );

  // Arbiter side
  modport slave (
    input  en, cnt_clr, req_L, req_W, req_E, req_S, W_full, E_full, S_full,
    output L_arb_res, W_arb_res, E_arb_res, S_arb_res,
    output L_xfer_cnt, W_xfer_cnt, E_xfer_cnt, S_xfer_cnt
  );

endinterface

// File: rtl/switch_rr_arbiter_rr_arb4.sv
// One output's 4-way round-robin arbiter: pointer, rotate-priority grant, transfer detect, counter.
module rr_arb4
  import switch_rr_arbiter_pkg::*;
#(
  parameter int unsigned CNTW = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_cnt_clr,
  input  port_vec_t       i_req,
  input  logic            i_full,
  output port_vec_t       o_grant_c,
  output logic [CNTW-1:0] o_cnt
);

  ptr_t            r_ptr;
  logic [CNTW-1:0] r_cnt;
  port_vec_t       w_grant;
  ptr_t            w_gidx;
  ptr_t            w_idx;
  logic            w_hit;
  logic            w_xfer;

  // Grant the first requester scanning down from the pointer, wrapping
  always_comb begin
    w_grant = '0;
    w_gidx  = r_ptr;
    w_idx   = '0;
    w_hit   = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_idx = PTR_W'(r_ptr - PTR_W'(k));
      if (!w_hit && i_req[w_idx]) begin
        w_grant[w_idx] = 1'b1;
        w_gidx         = w_idx;
        w_hit          = 1'b1;
      end
    end
  end

  // A flit moves only when granted and the downstream buffer has room
  assign w_xfer    = w_hit & ~i_full;
  assign o_grant_c = w_grant;
  assign o_cnt     = r_cnt;

  // Pointer drops the winner to lowest priority; counter clears or saturates
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ptr <= PTR_RST;
      r_cnt <= '0;
    end else begin
      if (w_xfer) begin
        r_ptr <= PTR_W'(w_gidx - 2'd1);
      end
      if (i_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_xfer && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNTW'(1);
      end
    end
  end

endmodule

// File: rtl/switch_rr_arbiter.sv
// Four independent per-output round-robin arbiters for the L/W/E/S switch stage.
module switch_rr_arbiter
  import switch_rr_arbiter_pkg::*;
#(
  parameter int unsigned CNTW = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  switch_rr_arbiter_if.slave  sw
);

  logic      w_gate;
  port_vec_t w_req_L;
  port_vec_t w_req_W;
  port_vec_t w_req_E;
  port_vec_t w_req_S;

  // Disabled or in reset: hide all requests so no grant and no transfer can occur
  assign w_gate  = rst_n & sw.en;
  assign w_req_L = w_gate ? sw.req_L : '0;
  assign w_req_W = w_gate ? sw.req_W : '0;
  assign w_req_E = w_gate ? sw.req_E : '0;
  assign w_req_S = w_gate ? sw.req_S : '0;

  // L output has no downstream full
  rr_arb4 #(.CNTW(CNTW)) u_arb_l (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_cnt_clr (sw.cnt_clr),
    .i_req     (w_req_L),
    .i_full    (1'b0),
    .o_grant_c (sw.L_arb_res),
    .o_cnt     (sw.L_xfer_cnt)
  );

  rr_arb4 #(.CNTW(CNTW)) u_arb_w (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_cnt_clr (sw.cnt_clr),
    .i_req     (w_req_W),
    .i_full    (sw.W_full),
    .o_grant_c (sw.W_arb_res),
    .o_cnt     (sw.W_xfer_cnt)
  );

  rr_arb4 #(.CNTW(CNTW)) u_arb_e (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_cnt_clr (sw.cnt_clr),
    .i_req     (w_req_E),
    .i_full    (sw.E_full),
    .o_grant_c (sw.E_arb_res),
    .o_cnt     (sw.E_xfer_cnt)
  );

  rr_arb4 #(.CNTW(CNTW)) u_arb_s (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_cnt_clr (sw.cnt_clr),
    .i_req     (w_req_S),
    .i_full    (sw.S_full),
    .o_grant_c (sw.S_arb_res),
    .o_cnt     (sw.S_xfer_cnt)
  );

endmodule

// File: tb/tb_switch_rr_arbiter.sv
// Bench for switch_rr_arbiter: directed scenarios plus random traffic against a reference model.
module tb_switch_rr_arbiter;

  logic clk;
  logic t_rst_n;
  logic t_en;
  logic t_clr;
  logic [3:0] t_req [4];   // 0=L 1=W 2=E 3=S outputs
  logic       t_full [4];

  logic       q4_en;
  logic       q4_clr;
  logic [3:0] q4_req_L;

  int n_checks;
  int n_fail;

  int          m_ptr [4];
  int unsigned m_cnt [4];

  logic [3:0]  a_grant [4];
  logic [15:0] a_cnt [4];

  switch_rr_arbiter_if #(.CNTW(16)) sw16 ();
  switch_rr_arbiter_if #(.CNTW(4))  sw4 ();

  switch_rr_arbiter #(.CNTW(16)) u_dut (
    .clk   (clk),
    .rst_n (t_rst_n),
    .sw    (sw16)
  );

  switch_rr_arbiter #(.CNTW(4)) u_dut4 (
    .clk   (clk),
    .rst_n (t_rst_n),
    .sw    (sw4)
  );

  assign sw16.en      = t_en;
  assign sw16.cnt_clr = t_clr;
  assign sw16.req_L   = t_req[0];
  assign sw16.req_W   = t_req[1];
  assign sw16.req_E   = t_req[2];
  assign sw16.req_S   = t_req[3];
  assign sw16.W_full  = t_full[1];
  assign sw16.E_full  = t_full[2];
  assign sw16.S_full  = t_full[3];

  assign a_grant[0] = sw16.L_arb_res;
  assign a_grant[1] = sw16.W_arb_res;
  assign a_grant[2] = sw16.E_arb_res;
  assign a_grant[3] = sw16.S_arb_res;
  assign a_cnt[0]   = sw16.L_xfer_cnt;
  assign a_cnt[1]   = sw16.W_xfer_cnt;
  assign a_cnt[2]   = sw16.E_xfer_cnt;
  assign a_cnt[3]   = sw16.S_xfer_cnt;

  assign sw4.en      = q4_en;
  assign sw4.cnt_clr = q4_clr;
  assign sw4.req_L   = q4_req_L;
  assign sw4.req_W   = 4'b0000;
  assign sw4.req_E   = 4'b0000;
  assign sw4.req_S   = 4'b0000;
  assign sw4.W_full  = 1'b0;
  assign sw4.E_full  = 1'b0;
  assign sw4.S_full  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference grant: walk priority list ptr, ptr-1, ... mod 4 and pick first requester
  function automatic logic [3:0] m_grant(input int o);
    if (!t_rst_n || !t_en) return 4'b0000;
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (m_ptr[o] - k + 8) % 4;
      if (t_req[o][i]) return 4'(1 << i);
    end
    return 4'b0000;
  endfunction

  // One clock: check mid-cycle against the model, then advance the model at the edge
  task automatic cycle(input int dir_o, input logic [3:0] dir_exp);
    logic [3:0] g [4];
    @(negedge clk);
    for (int o = 0; o < 4; o++) begin
      g[o] = m_grant(o);
      chk($sformatf("grant_o%0d", o), 32'(a_grant[o]), 32'(g[o]));
      chk($sformatf("cnt_o%0d", o), 32'(a_cnt[o]), m_cnt[o]);
    end
    if (dir_o >= 0) chk($sformatf("dir_grant_o%0d", dir_o), 32'(a_grant[dir_o]), 32'(dir_exp));
    @(posedge clk);
    for (int o = 0; o < 4; o++) begin
      if (!t_rst_n) begin
        m_ptr[o] = 3;
        m_cnt[o] = 0;
      end else begin
        logic xfer;
        xfer = (g[o] != 4'b0000) && ((o == 0) || !t_full[o]);
        if (xfer) begin
          for (int i = 0; i < 4; i++) if (g[o][i]) m_ptr[o] = (i + 3) % 4;
        end
        if (t_clr) m_cnt[o] = 0;
        else if (xfer && m_cnt[o] < 32'd65535) m_cnt[o] = m_cnt[o] + 1;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    for (int o = 0; o < 4; o++) begin
      t_req[o]  = 4'b0000;
      t_full[o] = 1'b0;
    end
    t_en  = 1'b1;
    t_clr = 1'b0;
  endtask

  initial begin
    logic [3:0] rot [5];
    rot[0] = 4'b1000; rot[1] = 4'b0100; rot[2] = 4'b0010; rot[3] = 4'b0001; rot[4] = 4'b1000;
    n_checks = 0;
    n_fail   = 0;
    for (int o = 0; o < 4; o++) begin
      m_ptr[o] = 3;
      m_cnt[o] = 0;
    end
    q4_en    = 1'b1;
    q4_clr   = 1'b0;
    q4_req_L = 4'b0000;
    idle_inputs();

    // Reset with requests present: grants forced to zero
    t_rst_n = 1'b0;
    for (int o = 0; o < 4; o++) t_req[o] = 4'($urandom_range(1, 15));
    @(posedge clk); #1;
    cycle(0, 4'b0000);
    cycle(1, 4'b0000);
    t_rst_n = 1'b1;
    idle_inputs();

    // Rotation on W
    t_req[1] = 4'b1111;
    for (int k = 0; k < 5; k++) cycle(1, rot[k]);
    t_req[1] = 4'b0000;
    chk("rot_w_cnt", 32'(a_cnt[1]), 32'd5);

    // Full stall on E
    t_req[2]  = 4'b0110;
    t_full[2] = 1'b1;
    for (int k = 0; k < 3; k++) cycle(2, 4'b0100);
    chk("stall_e_cnt", 32'(a_cnt[2]), 32'd0);
    t_full[2] = 1'b0;
    cycle(2, 4'b0100);
    cycle(2, 4'b0010);
    chk("stall_e_cnt_after", 32'(a_cnt[2]), 32'd2);
    idle_inputs();

    // L ignores full
    t_req[0] = 4'b1001;
    for (int o = 0; o < 4; o++) t_full[o] = 1'b1;
    for (int k = 0; k < 4; k++) cycle(0, (k % 2 == 0) ? 4'b1000 : 4'b0001);
    chk("l_full_cnt", 32'(a_cnt[0]), 32'd4);
    idle_inputs();

    // Enable gating on S
    t_req[3] = 4'b1111;
    cycle(3, 4'b1000);
    cycle(3, 4'b0100);
    t_en = 1'b0;
    for (int k = 0; k < 4; k++) cycle(3, 4'b0000);
    chk("en_s_cnt_hold", 32'(a_cnt[3]), 32'd2);
    t_en = 1'b1;
    cycle(3, 4'b0010);
    idle_inputs();

    // Counter saturation and clear priority on a 4-bit instance
    q4_req_L = 4'b1000;
    repeat (15) @(posedge clk);
    #1;
    chk("cnt4_fill", 32'(sw4.L_xfer_cnt), 32'd15);
    @(posedge clk); #1;
    chk("cnt4_sat", 32'(sw4.L_xfer_cnt), 32'd15);
    q4_clr = 1'b1;
    @(posedge clk); #1;
    chk("cnt4_clr_over_xfer", 32'(sw4.L_xfer_cnt), 32'd0);
    q4_clr   = 1'b0;
    q4_req_L = 4'b0000;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      for (int o = 0; o < 4; o++) begin
        t_req[o]  = 4'($urandom_range(0, 15));
        t_full[o] = ($urandom_range(0, 3) == 0);
      end
      t_en    = ($urandom_range(0, 7) != 0);
      t_clr   = ($urandom_range(0, 31) == 0);
      t_rst_n = ($urandom_range(0, 63) != 0);
      cycle(-1, 4'b0000);
    end
    t_rst_n = 1'b1;
    idle_inputs();

    // Mid-operation reset with ptr_W = 1 and counters nonzero
    t_rst_n = 1'b0;
    cycle(-1, 4'b0000);
    t_rst_n = 1'b1;
    for (int o = 0; o < 4; o++) t_req[o] = 4'b1111;
    cycle(1, 4'b1000);
    cycle(1, 4'b0100);
    chk("pre_rst_w_cnt", 32'(a_cnt[1]), 32'd2);
    t_rst_n = 1'b0;
    cycle(1, 4'b0000);
    for (int o = 0; o < 4; o++) chk($sformatf("post_rst_cnt_o%0d", o), 32'(a_cnt[o]), 32'd0);
    t_rst_n = 1'b1;
    cycle(1, 4'b1000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_rr_arbiter.md
# switch_rr_arbiter

Per-output round-robin arbiter for the 4-port (L, W, E, S) router switch stage. It takes per-output request vectors from the switch allocator and returns one-hot `*_arb_res` grants to it, combinationally in the same cycle. Per-output priority pointers advance only on a completed transfer, and per-output transfer counters support performance monitoring.

## Interface
- `CNTW`, 16: width of per-output transfer counters
- `clk` in 1: clock; only clock in block
- `rst_n` in 1: reset, synchronous, active-low
- `en` in 1: arbitration enable; low forces all grants to 0
- `cnt_clr` in 1: synchronous clear of all transfer counters
- `req_L`, `req_W`, `req_E`, `req_S` in 4 each: request vector per output port; bit3 = L input, bit2 = W input, bit1 = E input, bit0 = S input
- `W_full`, `E_full`, `S_full` in 1 each: downstream full for W/E/S outputs; L output has no full
- `L_arb_res`, `W_arb_res`, `E_arb_res`, `S_arb_res` out 4 each: one-hot grant per output, same bit order as requests, 4'b0000 = none; combinational
- `L_xfer_cnt`, `W_xfer_cnt`, `E_xfer_cnt`, `S_xfer_cnt` out CNTW each: saturating transfer counters, registered

## Operation
- Each output X has a 2-bit pointer `ptr_X`, naming the input index with highest priority.
- Priority order is `ptr`, `ptr-1`, … down to `ptr-3`, mod 4, by descending bit index with wrap.
- `X_arb_res` is one-hot on the first requesting index in that order.
  - It is 0000 if `req_X == 0` or `en == 0`.
- A transfer on output X is `|X_arb_res & ~X_full`. For L, transfer is `|L_arb_res`.
- On a transfer granted to index i: `ptr_X <= (i-1) mod 4`, so the granted input drops to lowest priority.
- With no transfer, including when grant is issued while full, `ptr_X` holds.
  - While full, the grant may move to a newly arriving higher-priority requester. No flit has moved, so this is legal.
- Outputs are fully independent. An input requesting several outputs may be granted by several outputs.
- Counters:
  - `cnt_clr` sets all to 0 and has priority over increment.
  - Otherwise each counter increments by 1 per transfer on its output.
  - Each counter saturates at all-ones.
- Reset, synchronous while `rst_n == 0` at posedge:
  - all `ptr_X` = 3 (L input highest);
  - all counters = 0.
  - `*_arb_res` are combinational. With `rst_n == 0` they are forced to 0000 regardless of requests.

## Timing
- Grant latency 0: `*_arb_res` is valid in the same cycle as `req_*`/`en`/`*_full`; no registers on the grant path.
- Pointer and counter updates take effect at the next posedge and affect grants from the following cycle.
- Full asserted and deasserted in consecutive cycles: the first non-full cycle completes the transfer and the pointer advances at that edge.
- Reset mid-operation: pointers and counters return to reset values at the first posedge with `rst_n == 0`; no partial update.
- `en` low: no transfers, pointers and counters hold; `cnt_clr` still acts.

## Structure
- Shared router package holds:
  - input index constants `IDX_L=3`, `IDX_W=2`, `IDX_E=1`, `IDX_S=0`;
  - pointer reset value `PTR_RST=2'd3`;
  - the 4-bit request/grant bit-order definition, common with the switch allocator.
- Sub-module `rr_arb4`, instantiated 4 times. Each instance contains:
  - pointer register, rotate-priority grant logic, transfer detect, saturating counter;
  - `full` input, tied 0 for the L instance.
- Top level only wires the instances and applies `en` / reset gating.

## Test plan
- Rotation: reset, `req_W=4'b1111`, `W_full=0`, 5 cycles → `W_arb_res` = 1000, 0100, 0010, 0001, 1000; `W_xfer_cnt=5`.
- Full stall: `req_E=4'b0110`, `E_full=1` for 3 cycles, then 0 → `E_arb_res=0100` for all 3 stalled cycles with `ptr_E` and count unchanged; then 0100 transfers, next cycle 0010.
- L ignores full: `req_L=4'b1001` held, all full inputs=1 → `L_arb_res` alternates 1000/0001 every cycle and `L_xfer_cnt` increments every cycle.
- Enable gating: after 2 transfers on S, `en=0` with `req_S=4'b1111` for 4 cycles → `S_arb_res=0000`, `ptr_S` and `S_xfer_cnt` hold. `en=1` resumes from the held pointer.
- Counter edges:
  - preload `CNTW=4` build to 15, then one transfer → stays 15;
  - `cnt_clr=1` with a simultaneous transfer → 0.
- Mid-operation reset: `ptr_W=1`, counters nonzero, `rst_n=0` one cycle with `req_W=4'b1111` → `W_arb_res=0000` during reset. All counters are 0 after the edge, and the first post-reset grant is 1000.
